// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA receive side: sync recovery, pixel strobes, line/frame measurement, lock tracking
module vga_capture #(
  parameter int CLK_DIV  = 4,
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Hsync,
  input  logic       Vsync,
  input  logic [2:0] vgaRed,
  input  logic [2:0] vgaGreen,
  input  logic [1:0] vgaBlue,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [7:0] pix_rgb,
  output logic       frame_start,
  output logic [9:0] line_len,
  output logic       err_hline,
  output logic       err_vframe,
  output logic       locked
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_MID  = PW'(CLK_DIV / 2);
  localparam logic [9:0]  H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  H_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [10:0] H_LEN   = 11'(H_TOTAL);
  localparam logic [10:0] V_LEN   = 11'(V_TOTAL);

  typedef enum logic [1:0] {UNLOCK, GOOD1, LOCK} lock_e;

  logic          hs_s1_q, hs_s2_q, hs_s3_q, vs_s1_q, vs_s2_q, vs_s3_q;
  logic [7:0]    rgb_s1_q, rgb_s2_q;
  logic [PW-1:0] ph_q, ph_d;
  logic [9:0]    hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic          h_seen_q, h_seen_d, v_seen_q, v_seen_d, v_pend_q, v_pend_d;
  logic          frame_bad_q, frame_bad_d;
  logic [9:0]    line_len_q, line_len_d;
  logic          pix_valid_q, pix_valid_d;
  logic [9:0]    pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [7:0]    pix_rgb_q, pix_rgb_d;
  logic          frame_start_q, err_hline_q, err_vframe_q;
  lock_e         state_q, state_d;

  logic          hs_fall, vs_fall, frame_end, herr_now, verr_now, fend_ok, sample;
  logic [10:0]   hcnt_inc, vcnt_inc;

  always_comb begin
    hs_fall   = hs_s3_q & ~hs_s2_q;
    vs_fall   = vs_s3_q & ~vs_s2_q;
    hcnt_inc  = {1'b0, hcnt_q} + 11'd1;
    vcnt_inc  = {1'b0, vcnt_q} + 11'd1;
    // A Vsync fall only takes effect at a line boundary, so vcnt always restarts with a fresh line.
    frame_end = hs_fall & (v_pend_q | vs_fall);
    herr_now  = hs_fall & h_seen_q & (hcnt_inc != H_LEN);
    verr_now  = frame_end & v_seen_q & (vcnt_inc != V_LEN);
    fend_ok   = frame_end & v_seen_q & ~frame_bad_q & ~herr_now & ~verr_now;
    sample    = ~hs_fall & (ph_q == PH_MID)
              & (hcnt_q >= H_START) & (hcnt_q < H_END)
              & (vcnt_q >= V_START) & (vcnt_q < V_END);

    ph_d        = hs_fall ? '0 : ph_q + PW'(1);
    hcnt_d      = hcnt_q;
    line_len_d  = line_len_q;
    vcnt_d      = vcnt_q;
    if (hs_fall) begin
      hcnt_d     = '0;
      line_len_d = hcnt_inc[10] ? 10'h3FF : hcnt_inc[9:0];
      if (frame_end)
        vcnt_d = '0;
      else if (vcnt_q != 10'h3FF)
        vcnt_d = vcnt_q + 10'd1;
    end else if (ph_q == PH_LAST && hcnt_q != 10'h3FF) begin
      hcnt_d = hcnt_q + 10'd1;
    end

    h_seen_d    = h_seen_q | hs_fall;
    v_seen_d    = v_seen_q | frame_end;
    v_pend_d    = frame_end ? 1'b0 : (v_pend_q | vs_fall);
    frame_bad_d = frame_end ? 1'b0 : (frame_bad_q | herr_now);

    pix_valid_d = sample;
    pix_x_d     = sample ? hcnt_q - H_START : pix_x_q;
    pix_y_d     = sample ? vcnt_q - V_START : pix_y_q;
    pix_rgb_d   = sample ? rgb_s2_q : pix_rgb_q;
  end

  // Errors are seen through their registered pulses, so they win over any same-cycle advance.
  always_comb begin
    state_d = state_q;
    if (err_hline_q | err_vframe_q) begin
      state_d = UNLOCK;
    end else if (fend_ok) begin
      case (state_q)
        UNLOCK:  state_d = GOOD1;
        GOOD1:   state_d = LOCK;
        default: state_d = LOCK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_s1_q <= 1'b0; hs_s2_q <= 1'b0; hs_s3_q <= 1'b0;
      vs_s1_q <= 1'b0; vs_s2_q <= 1'b0; vs_s3_q <= 1'b0;
      rgb_s1_q <= '0; rgb_s2_q <= '0;
      ph_q <= '0; hcnt_q <= '0; vcnt_q <= '0;
      h_seen_q <= 1'b0; v_seen_q <= 1'b0; v_pend_q <= 1'b0; frame_bad_q <= 1'b0;
      line_len_q <= '0;
      pix_valid_q <= 1'b0; pix_x_q <= '0; pix_y_q <= '0; pix_rgb_q <= '0;
      frame_start_q <= 1'b0; err_hline_q <= 1'b0; err_vframe_q <= 1'b0;
      state_q <= UNLOCK;
    end else begin
      hs_s1_q <= Hsync;   hs_s2_q <= hs_s1_q; hs_s3_q <= hs_s2_q;
      vs_s1_q <= Vsync;   vs_s2_q <= vs_s1_q; vs_s3_q <= vs_s2_q;
      rgb_s1_q <= {vgaRed, vgaGreen, vgaBlue};
      rgb_s2_q <= rgb_s1_q;
      ph_q <= ph_d; hcnt_q <= hcnt_d; vcnt_q <= vcnt_d;
      h_seen_q <= h_seen_d; v_seen_q <= v_seen_d; v_pend_q <= v_pend_d; frame_bad_q <= frame_bad_d;
      line_len_q <= line_len_d;
      pix_valid_q <= pix_valid_d; pix_x_q <= pix_x_d; pix_y_q <= pix_y_d; pix_rgb_q <= pix_rgb_d;
      frame_start_q <= frame_end; err_hline_q <= herr_now; err_vframe_q <= verr_now;
      state_q <= state_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign frame_start = frame_start_q;
  assign line_len    = line_len_q;
  assign err_hline   = err_hline_q;
  assign err_vframe  = err_vframe_q;
  assign locked      = (state_q == LOCK);

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - directed-vector bench for vga_capture on a scaled-down raster
module tb_vga_capture;
  localparam int CLK_DIV = 4, H_TOTAL = 20, H_SYNC = 3, H_BP = 2, H_ACTIVE = 12;
  localparam int V_TOTAL = 12, V_SYNC = 2, V_BP = 2, V_ACTIVE = 6;
  localparam int HOFF = H_SYNC + H_BP;
  localparam int VOFF = V_SYNC + V_BP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       Hsync = 1'b1, Vsync = 1'b1;
  logic [2:0] vgaRed = '0, vgaGreen = '0;
  logic [1:0] vgaBlue = '0;
  logic       pix_valid, frame_start, err_hline, err_vframe, locked;
  logic [9:0] pix_x, pix_y, line_len;
  logic [7:0] pix_rgb;

  int n_vec = 0, n_miss = 0;
  int cyc = 0, n_fs = 0, n_eh = 0, n_ev = 0, nvalid = 0;
  int fs_cyc = 0, eh_cyc = 0, eh_len = 0, rise_cyc = -1, fall_cyc = -1, last_cyc = 0;
  int exp_x = 0, exp_y = 0, last_x = 0, last_y = 0;
  bit armed = 0, have_prev = 0, locked_prev = 0;

  always #5 clk = ~clk;

  vga_capture #(
    .CLK_DIV(CLK_DIV), .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Hsync(Hsync), .Vsync(Vsync),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .line_len(line_len),
    .err_hline(err_hline), .err_vframe(err_vframe), .locked(locked)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      armed = 0;
    end else begin
      if (pix_valid && armed) begin
        chk("pix_x", pix_x, exp_x);
        chk("pix_y", pix_y, exp_y);
        chk("pix_rgb", pix_rgb, exp_x & 8'hFF);
        if (have_prev && exp_x != 0) chk("strobe_gap", cyc - last_cyc, CLK_DIV);
        have_prev = 1; last_cyc = cyc; last_x = pix_x; last_y = pix_y; nvalid++;
        exp_x++;
        if (exp_x == H_ACTIVE) begin exp_x = 0; exp_y++; end
      end
      if (frame_start) begin
        n_fs++; fs_cyc = cyc;
        if (armed) begin
          chk("frame_pixels", nvalid, H_ACTIVE * V_ACTIVE);
          chk("last_x", last_x, H_ACTIVE - 1);
          chk("last_y", last_y, V_ACTIVE - 1);
        end
        armed = 1; nvalid = 0; exp_x = 0; exp_y = 0; have_prev = 0;
      end
      if (err_vframe) begin n_ev++; chk("verr_with_fs", frame_start, 1); end
      if (err_hline) begin n_eh++; eh_cyc = cyc; eh_len = line_len; end
      if (locked && !locked_prev) rise_cyc = cyc;
      if (!locked && locked_prev) fall_cyc = cyc;
    end
    locked_prev = locked;
  end

  task automatic drive_px(input int line, input int p, input bit vs_low);
    bit act;
    act = (line >= VOFF) && (line < VOFF + V_ACTIVE) && (p >= HOFF) && (p < HOFF + H_ACTIVE);
    Hsync = (p >= H_SYNC);
    Vsync = ~vs_low;
    {vgaRed, vgaGreen, vgaBlue} = act ? 8'(p - HOFF) : 8'hA5;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic send_line(input int line, input int p0, input int len, input bit early_vs);
    for (int p = p0; p < len; p++) drive_px(line, p, (line < V_SYNC) || (early_vs && p >= 10));
  endtask

  task automatic send_frame(input int l0, input int nlines, input int short_line, input bit early_vs);
    for (int l = l0; l < nlines; l++)
      send_line(l, 0, (l == short_line) ? H_TOTAL - 1 : H_TOTAL, early_vs && (l == nlines - 1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_xy"}, {pix_x, pix_y}, 0);
    chk({tag, "_rgb"}, pix_rgb, 0);
    chk({tag, "_pulses"}, {frame_start, err_hline, err_vframe}, 0);
    chk({tag, "_line_len"}, line_len, 0);
    chk({tag, "_locked"}, locked, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 chk_all_zero("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send_frame(0, V_TOTAL, -1, 0);
    chk("f1_locked", locked, 0);
    chk("f1_line_len", line_len, H_TOTAL);
    chk("f1_fs_count", n_fs, 1);
    send_frame(0, V_TOTAL, -1, 0);
    chk("f2_locked", locked, 0);
    send_frame(0, V_TOTAL, -1, 0);
    chk("f3_locked", locked, 1);
    chk("lock_rise_at_fs", rise_cyc, fs_cyc);
    chk("f3_no_errs", n_eh + n_ev, 0);

    send_frame(0, V_TOTAL, 6, 0);
    chk("short_line_errs", n_eh, 1);
    chk("short_line_len", eh_len, H_TOTAL - 1);
    chk("lock_drop_lag", fall_cyc - eh_cyc, 1);
    chk("f4_locked", locked, 0);
    chk("f4_line_len", line_len, H_TOTAL);
    send_frame(0, V_TOTAL, -1, 0);
    chk("f5_locked", locked, 0);
    send_frame(0, V_TOTAL, -1, 0);
    chk("f6_locked", locked, 0);
    send_frame(0, V_TOTAL, -1, 0);
    chk("f7_relocked", locked, 1);

    send_frame(0, V_TOTAL - 1, -1, 0);
    chk("f8_locked", locked, 1);
    chk("f8_no_verr", n_ev, 0);
    send_frame(0, V_TOTAL, -1, 1);
    chk("short_frame_verr", n_ev, 1);
    chk("f9_locked", locked, 0);
    send_frame(0, V_TOTAL, -1, 0);
    chk("deferred_vs_verr", n_ev, 1);
    chk("f10_fs_count", n_fs, 10);

    send_frame(0, 6, -1, 0);
    send_line(6, 0, 9, 0);
    chk("pre_rst_locked", locked, 1);
    chk("pre_rst_line_len", line_len, H_TOTAL);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_line(6, 9, H_TOTAL, 0);
    send_frame(7, V_TOTAL, -1, 0);
    send_frame(0, V_TOTAL, -1, 0);
    chk("f12_hline_errs", n_eh, 1);
    chk("f12_vframe_errs", n_ev, 1);
    chk("f12_locked", locked, 0);
    send_frame(0, V_TOTAL, -1, 0);
    chk("f13_locked", locked, 0);
    chk("f13_fs_count", n_fs, 13);
    chk("f13_errs", n_eh + n_ev, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
